// File: rtl/miriscv_mdu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | miriscv_mdu_pkg : opcode encodings shared by the MDU blocks      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package miriscv_mdu_pkg;

   localparam int MDU_OP_W = 3;

   localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
   localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
   localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
   localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
   localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
   localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
   localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
   localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/miriscv_div_radix2_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | miriscv_div_radix2_if : request/result bundle of the divider     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface miriscv_div_radix2_if #(
   parameter int XLEN     = 32,
   parameter int MDU_OP_W = miriscv_mdu_pkg::MDU_OP_W
);
   logic                div_start_i;
   logic [XLEN-1:0]     port_a_i;
   logic [XLEN-1:0]     port_b_i;
   logic [MDU_OP_W-1:0] mdu_op_i;
   logic                zero_i;
   logic                kill_i;
   logic                keep_i;
   logic [XLEN-1:0]     div_result_o;
   logic [XLEN-1:0]     rem_result_o;
   logic                div_stall_req_o;

   modport master (
      output div_start_i, port_a_i, port_b_i, mdu_op_i, zero_i, kill_i, keep_i,
      input  div_result_o, rem_result_o, div_stall_req_o
   );

   modport slave (
      input  div_start_i, port_a_i, port_b_i, mdu_op_i, zero_i, kill_i, keep_i,
      output div_result_o, rem_result_o, div_stall_req_o
   );
endinterface
`default_nettype wire

// File: rtl/miriscv_div_radix2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | miriscv_div_radix2 : restoring radix-2 divider, one bit / cycle  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module miriscv_div_radix2 #(
   parameter int XLEN     = 32,
   parameter int MDU_OP_W = miriscv_mdu_pkg::MDU_OP_W
) (
   input  wire                   clk_i,
   input  wire                   arstn_i,
   miriscv_div_radix2_if.slave   div_if
);

   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [XLEN-1:0]     a_raw_q,   a_raw_d;
   logic [XLEN-1:0]     divisor_q, divisor_d;
   logic [XLEN-1:0]     quot_q,    quot_d;
   logic [XLEN:0]       prem_q,    prem_d;
   logic [MDU_OP_W-1:0] op_q,      op_d;
   logic                sign_a_q,  sign_a_d;
   logic                sign_b_q,  sign_b_d;
   logic [XLEN-1:0]     div_res_q, div_res_d;
   logic [XLEN-1:0]     rem_res_q, rem_res_d;

   logic                signed_in;
   logic                signed_q;
   logic [XLEN+1:0]     shift_ext;
   logic [XLEN+1:0]     diff;
   logic                borrow;
   logic                stall;

   assign signed_in = (div_if.mdu_op_i == miriscv_mdu_pkg::MDU_DIV) ||
                      (div_if.mdu_op_i == miriscv_mdu_pkg::MDU_REM);
   assign signed_q  = (op_q == miriscv_mdu_pkg::MDU_DIV) ||
                      (op_q == miriscv_mdu_pkg::MDU_REM);

   // Next dividend bit enters the partial remainder; a borrow means "restore".
   assign shift_ext = {prem_q, quot_q[XLEN-1]};
   assign diff      = shift_ext - {2'b00, divisor_q};
   assign borrow    = diff[XLEN+1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_raw_d   = a_raw_q;
      divisor_d = divisor_q;
      quot_d    = quot_q;
      prem_d    = prem_q;
      op_d      = op_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      div_res_d = div_res_q;
      rem_res_d = rem_res_q;

      if (div_if.kill_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (div_if.div_start_i && !div_if.keep_i) begin
                  a_raw_d   = div_if.port_a_i;
                  op_d      = div_if.mdu_op_i;
                  sign_a_d  = signed_in && div_if.port_a_i[XLEN-1];
                  sign_b_d  = signed_in && div_if.port_b_i[XLEN-1];
                  quot_d    = (signed_in && div_if.port_a_i[XLEN-1]) ?
                              -div_if.port_a_i : div_if.port_a_i;
                  divisor_d = (signed_in && div_if.port_b_i[XLEN-1]) ?
                              -div_if.port_b_i : div_if.port_b_i;
                  prem_d    = '0;
                  cnt_d     = '0;
                  state_d   = ST_RUN;
               end
            end
            ST_RUN: begin
               // zero_i arrives one cycle after the operands, i.e. now.
               if ((cnt_q == '0) && div_if.zero_i) begin
                  div_res_d = '1;
                  rem_res_d = a_raw_q;
                  state_d   = ST_DONE;
               end else begin
                  prem_d = borrow ? shift_ext[XLEN:0] : diff[XLEN:0];
                  quot_d = {quot_q[XLEN-2:0], ~borrow};
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(XLEN - 1)) begin
                     state_d = ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               div_res_d = (signed_q && (sign_a_q ^ sign_b_q)) ? -quot_q : quot_q;
               rem_res_d = (signed_q && sign_a_q) ? -prem_q[XLEN-1:0] : prem_q[XLEN-1:0];
               state_d   = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stall = (state_q == ST_RUN) || (state_q == ST_FIX) ||
              ((state_q == ST_IDLE) && div_if.div_start_i && !div_if.keep_i);
      // Reset gating keeps the request low while arstn_i is asserted.
      stall = stall && !div_if.kill_i && arstn_i;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         a_raw_q   <= '0;
         divisor_q <= '0;
         quot_q    <= '0;
         prem_q    <= '0;
         op_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         div_res_q <= '0;
         rem_res_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_raw_q   <= a_raw_d;
         divisor_q <= divisor_d;
         quot_q    <= quot_d;
         prem_q    <= prem_d;
         op_q      <= op_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         div_res_q <= div_res_d;
         rem_res_q <= rem_res_d;
      end
   end

   assign div_if.div_result_o    = div_res_q;
   assign div_if.rem_result_o    = rem_res_q;
   assign div_if.div_stall_req_o = stall;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_div_radix2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_miriscv_div_radix2 : scoreboard bench for the radix-2 divider |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_miriscv_div_radix2;

   localparam int XLEN = 32;
   localparam int OPW  = miriscv_mdu_pkg::MDU_OP_W;
   localparam logic [OPW-1:0] OP_DIV  = miriscv_mdu_pkg::MDU_DIV;
   localparam logic [OPW-1:0] OP_DIVU = miriscv_mdu_pkg::MDU_DIVU;
   localparam logic [OPW-1:0] OP_REM  = miriscv_mdu_pkg::MDU_REM;
   localparam logic [OPW-1:0] OP_REMU = miriscv_mdu_pkg::MDU_REMU;

   logic clk   = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   miriscv_div_radix2_if #(.XLEN(XLEN), .MDU_OP_W(OPW)) dif ();

   miriscv_div_radix2 #(.XLEN(XLEN), .MDU_OP_W(OPW)) dut (
      .clk_i   (clk),
      .arstn_i (arstn),
      .div_if  (dif.slave)
   );

   typedef struct {
      logic [XLEN-1:0] q;
      logic [XLEN-1:0] r;
      int              stall;
      string           name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a falling stall marks the end of a transaction.
   initial begin
      int   cnt;
      logic prev;
      exp_t e;
      cnt  = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (dif.div_stall_req_o) begin
            cnt++;
         end else if (prev) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_txn: stall fell after %0d cycles, no transaction expected", cnt);
            end else begin
               e = sb.pop_front();
               check({e.name, " quot"},  dif.div_result_o, e.q);
               check({e.name, " rem"},   dif.rem_result_o, e.r);
               check({e.name, " stall"}, 32'(cnt), 32'(e.stall));
            end
            cnt = 0;
         end
         prev = dif.div_stall_req_o;
      end
   end

   task automatic expect_txn(input string name, input logic [31:0] q,
                             input logic [31:0] r, input int stall);
      exp_t e;
      e.q = q; e.r = r; e.stall = stall; e.name = name;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #2;
      dif.div_start_i = 1'b1;
      dif.mdu_op_i    = op;
      dif.port_a_i    = a;
      dif.port_b_i    = b;
      @(posedge clk); #2;
      dif.div_start_i = 1'b0;
      dif.zero_i      = (b == 32'd0);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!dif.div_stall_req_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: stall still high, required low within 100 cycles", name);
      end
      @(posedge clk); #2;
      dif.zero_i = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [OPW-1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input int stall);
      expect_txn(name, q, r, stall);
      issue(op, a, b);
      wait_done(name);
   endtask

   initial begin
      dif.div_start_i = 1'b0;
      dif.port_a_i    = '0;
      dif.port_b_i    = '0;
      dif.mdu_op_i    = OP_DIVU;
      dif.zero_i      = 1'b0;
      dif.kill_i      = 1'b0;
      dif.keep_i      = 1'b0;

      @(negedge clk);
      check("reset quot",  dif.div_result_o, 32'd0);
      check("reset rem",   dif.rem_result_o, 32'd0);
      check("reset stall", 32'(dif.div_stall_req_o), 32'd0);
      @(posedge clk); #2;
      arstn = 1'b1;

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 34);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd14, 32'd2, 34);
      run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
      run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
      run_op("div_100_m7", OP_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 34);
      run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
      run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34);
      run_op("divu_5_10",  OP_DIVU, 32'd5, 32'd10, 32'd0, 32'd5, 34);
      run_op("div_by_0",   OP_DIV,  32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 2);
      run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);

      // keep_i blocks a start and the previous result holds
      @(posedge clk); #2;
      dif.keep_i      = 1'b1;
      dif.div_start_i = 1'b1;
      dif.mdu_op_i    = OP_DIVU;
      dif.port_a_i    = 32'd50;
      dif.port_b_i    = 32'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("keep stall", 32'(dif.div_stall_req_o), 32'd0);
         check("keep quot",  dif.div_result_o, 32'h8000_0000);
         check("keep rem",   dif.rem_result_o, 32'd0);
      end
      @(posedge clk); #2;
      dif.div_start_i = 1'b0;
      @(posedge clk); #2;
      dif.keep_i = 1'b0;

      // kill in RUN cycle 10: outputs keep the overflow result
      expect_txn("kill_run10", 32'h8000_0000, 32'd0, 11);
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #2;
      dif.kill_i = 1'b1;
      @(posedge clk); #2;
      dif.kill_i = 1'b0;
      run_op("divu_9_3_after_kill", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 34);

      // async reset in RUN cycle 5
      expect_txn("reset_run5", 32'd0, 32'd0, 6);
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #2;
      arstn = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      arstn = 1'b1;
      run_op("divu_9_3_after_reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 34);

      repeat (4) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
